fd_reg: RTL and testbench
=========================

FD_REG -- requirements
Module: fd_reg

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge, reset==0 resets.
REQ-003 SHALL have port: stall  input  1  hazard stall from D-stage hazard unit; 1 = hold D contents.
REQ-004 SHALL have port: Req  input  1  exception/interrupt request from CP0; 1 = flush and redirect.
REQ-005 SHALL have port: eret_D  input  1  eret currently decoded in D; 1 = squash instruction in F.
REQ-006 SHALL have port: F_pc  input  32  PC of instruction in F.
REQ-007 SHALL have port: F_instr  input  32  instruction word read from IM at F_pc.
REQ-008 SHALL have port: F_bd  input  1  F instruction sits in a branch/jump delay slot.
REQ-009 SHALL have port: D_pc  output  32  registered PC for D.
REQ-010 SHALL have port: D_instr  output  32  registered instruction for D (0 = nop).
REQ-011 SHALL have port: D_exccode  output  5  registered fetch exception code; 0 = none.
REQ-012 SHALL have port: D_bd  output  1  registered delay-slot flag.
REQ-013 SHALL have port: D_valid  output  1  1 = D holds a real fetched instruction, 0 = bubble.

Function
REQ-014 SHALL detect fetch exception combinationally: F_pc[1:0]!=0 or F_pc<0x0000_3000 or F_pc>0x0000_6FFC -> exccode 5'd4 (AdEL), else 5'd0.
REQ-015 SHALL, on a fetch exception, load D_instr=0 while keeping D_pc=F_pc, D_bd=F_bd, D_valid=1.
REQ-016 SHALL update state only on rising clk edge; latency F->D exactly one cycle.
REQ-017 SHALL apply per-edge priority: reset > Req > stall > eret_D > normal load.
REQ-018 SHALL on Req==1 (regardless of stall/eret_D) load D_pc=0x0000_4180, D_instr=0, D_exccode=0, D_bd=0, D_valid=0.
REQ-019 SHALL on stall==1 and Req==0 hold all outputs unchanged (eret_D ignored while stalled).
REQ-020 SHALL on eret_D==1, stall==0, Req==0 load D_pc=F_pc, D_instr=0, D_exccode=0, D_bd=0, D_valid=0 (squash).
REQ-021 SHALL otherwise load F_pc, F_instr (or 0 per REQ-015), fetch exccode, F_bd, D_valid=1.
REQ-022 SHALL treat consecutive stall cycles without limit; release resumes normal load on next edge.
REQ-023 SHALL produce no combinational path from any input to any output.

Reset
REQ-024 SHALL on reset==0 set D_pc=0x0000_3000, D_instr=0, D_exccode=0, D_bd=0, D_valid=0, overriding Req/stall/eret_D.
REQ-025 SHALL resume normal loading on the first edge after reset returns to 1; reset asserted mid-stall discards held instruction.

Structure
REQ-026 SHALL take from shared package: PC_RESET=0x0000_3000, PC_HANDLER=0x0000_4180, TEXT_LO=0x0000_3000, TEXT_HI=0x0000_6FFC, EXC_NONE=5'd0, EXC_ADEL=5'd4.
REQ-027 SHALL place address check (REQ-014) in one combinational sub-module fetch_exc_check (in: pc 32; out: exccode 5).
REQ-028 SHALL keep all D_* registers in fd_reg itself, one clocked process.

Verification
REQ-029 SHALL cover: reset==0 one edge with F_pc=0x3010 -> D_pc=0x3000, D_instr=0, D_valid=0.
REQ-030 SHALL cover: F_pc=0x3004, F_instr=0x24010001, F_bd=1 -> next edge D_pc=0x3004, D_instr=0x24010001, D_bd=1, D_exccode=0, D_valid=1.
REQ-031 SHALL cover: F_pc=0x3002 and F_pc=0x7000 -> D_exccode=4, D_instr=0, D_pc=F_pc, D_valid=1.
REQ-032 SHALL cover: stall=1 three edges with changing F_pc -> D_* unchanged; stall=1 with Req=1 -> D_pc=0x4180, D_valid=0.
REQ-033 SHALL cover: eret_D=1, stall=0, F_pc=0x3008 -> D_pc=0x3008, D_instr=0, D_valid=0; eret_D=1 with stall=1 -> hold.
REQ-034 SHALL cover: reset==0 simultaneous with Req=1 -> D_pc=0x3000, not 0x4180.

Source files
------------

// File: rtl/fd_reg_pkg.sv
// Shared constants and the F->D pipeline register payload.
package fd_reg_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned EXC_W   = 5;

    localparam logic [PC_W-1:0]  PC_RESET   = 32'h0000_3000;
    localparam logic [PC_W-1:0]  PC_HANDLER = 32'h0000_4180;
    localparam logic [PC_W-1:0]  TEXT_LO    = 32'h0000_3000;
    localparam logic [PC_W-1:0]  TEXT_HI    = 32'h0000_6FFC;
    localparam logic [EXC_W-1:0] EXC_NONE   = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL   = 5'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [EXC_W-1:0]   exccode;
        logic               bd;
        logic               valid;
    } d_stage_t;

endpackage

// File: rtl/fd_reg_fetch_exc_check.sv
// Combinational fetch address check: misaligned or outside the text segment -> AdEL.
module fetch_exc_check
    import fd_reg_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    output logic [EXC_W-1:0] exccode
);

    always_comb begin
        exccode = EXC_NONE;
        if ((pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI)) begin
            exccode = EXC_ADEL;
        end
    end

endmodule

// File: rtl/fd_reg.sv
// F->D pipeline register with stall hold, exception flush and eret squash.
module fd_reg
    import fd_reg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               Req,
    input  logic               eret_D,
    input  logic [PC_W-1:0]    F_pc,
    input  logic [INSTR_W-1:0] F_instr,
    input  logic               F_bd,
    output logic [PC_W-1:0]    D_pc,
    output logic [INSTR_W-1:0] D_instr,
    output logic [EXC_W-1:0]   D_exccode,
    output logic               D_bd,
    output logic               D_valid
);

    logic [EXC_W-1:0] f_exccode_c;
    d_stage_t         load_c;
    d_stage_t         d_q;

    fetch_exc_check u_exc_check (
        .pc      (F_pc),
        .exccode (f_exccode_c)
    );

    // Normal-load payload; a faulting fetch enters D as a nop carrying the code.
    always_comb begin
        load_c.pc      = F_pc;
        load_c.instr   = F_instr;
        load_c.exccode = f_exccode_c;
        load_c.bd      = F_bd;
        load_c.valid   = 1'b1;
        if (f_exccode_c != EXC_NONE) begin
            load_c.instr = '0;
        end
    end

    // Priority: reset > Req > stall > eret_D > load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q.pc      <= PC_RESET;
            d_q.instr   <= '0;
            d_q.exccode <= EXC_NONE;
            d_q.bd      <= 1'b0;
            d_q.valid   <= 1'b0;
        end else if (Req) begin
            d_q.pc      <= PC_HANDLER;
            d_q.instr   <= '0;
            d_q.exccode <= EXC_NONE;
            d_q.bd      <= 1'b0;
            d_q.valid   <= 1'b0;
        end else if (!stall) begin
            if (eret_D) begin
                d_q.pc      <= F_pc;
                d_q.instr   <= '0;
                d_q.exccode <= EXC_NONE;
                d_q.bd      <= 1'b0;
                d_q.valid   <= 1'b0;
            end else begin
                d_q <= load_c;
            end
        end
    end

    assign D_pc      = d_q.pc;
    assign D_instr   = d_q.instr;
    assign D_exccode = d_q.exccode;
    assign D_bd      = d_q.bd;
    assign D_valid   = d_q.valid;

endmodule

// File: tb/tb_fd_reg.sv
// Directed bench for fd_reg: expectations queued at drive time, checked after each edge.
module tb_fd_reg;
    import fd_reg_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, Req, eret_D, F_bd;
    logic [31:0] F_pc, F_instr;
    logic [31:0] D_pc, D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd, D_valid;

    d_stage_t model_q;
    d_stage_t exp_q[$];
    int       n_cmp = 0;
    int       n_err = 0;

    fd_reg dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .Req       (Req),
        .eret_D    (eret_D),
        .F_pc      (F_pc),
        .F_instr   (F_instr),
        .F_bd      (F_bd),
        .D_pc      (D_pc),
        .D_instr   (D_instr),
        .D_exccode (D_exccode),
        .D_bd      (D_bd),
        .D_valid   (D_valid)
    );

    always #5 clk = ~clk;

    function automatic d_stage_t model(input d_stage_t prev, input logic r, input logic rq,
                                       input logic st, input logic er, input logic [31:0] pc,
                                       input logic [31:0] ins, input logic bd);
        d_stage_t n;
        logic     bad;
        bad = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
        if (!r)      n = '{pc: 32'h0000_3000, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
        else if (rq) n = '{pc: 32'h0000_4180, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
        else if (st) n = prev;
        else if (er) n = '{pc: pc, instr: 32'h0, exccode: 5'd0, bd: 1'b0, valid: 1'b0};
        else         n = '{pc: pc, instr: bad ? 32'h0 : ins, exccode: bad ? 5'd4 : 5'd0,
                           bd: bd, valid: 1'b1};
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic rq, input logic st,
                        input logic er, input logic [31:0] pc, input logic [31:0] ins,
                        input logic bd);
        d_stage_t e;
        @(negedge clk);
        reset = r; Req = rq; stall = st; eret_D = er; F_pc = pc; F_instr = ins; F_bd = bd;
        model_q = model(model_q, r, rq, st, er, pc, ins, bd);
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".pc"},      D_pc,              e.pc);
        check({tag, ".instr"},   D_instr,           e.instr);
        check({tag, ".exccode"}, 32'(D_exccode),    32'(e.exccode));
        check({tag, ".bd"},      32'(D_bd),         32'(e.bd));
        check({tag, ".valid"},   32'(D_valid),      32'(e.valid));
    endtask

    initial begin
        model_q = '0;
        reset = 1'b0; Req = 1'b0; stall = 1'b0; eret_D = 1'b0;
        F_pc = 32'h0; F_instr = 32'h0; F_bd = 1'b0;

        //   tag            rst  Req  stl  eret  F_pc          F_instr       F_bd
        step("reset",       0,   0,   0,   0,    32'h0000_3010, 32'h1111_1111, 1);
        step("rst_req",     0,   1,   0,   0,    32'h0000_3010, 32'h1111_1111, 0);
        step("load",        1,   0,   0,   0,    32'h0000_3004, 32'h2401_0001, 1);
        step("misalign",    1,   0,   0,   0,    32'h0000_3002, 32'hDEAD_BEEF, 0);
        step("above_hi",    1,   0,   0,   0,    32'h0000_7000, 32'hDEAD_BEEF, 1);
        step("below_lo",    1,   0,   0,   0,    32'h0000_2FFC, 32'hDEAD_BEEF, 0);
        step("at_hi",       1,   0,   0,   0,    32'h0000_6FFC, 32'h0000_0020, 0);
        step("at_lo",       1,   0,   0,   0,    32'h0000_3000, 32'h3C01_1234, 1);
        step("pre_stall",   1,   0,   0,   0,    32'h0000_3010, 32'h8C22_0004, 0);
        step("stall1",      1,   0,   1,   0,    32'h0000_3014, 32'hAAAA_0001, 1);
        step("stall2",      1,   0,   1,   0,    32'h0000_3018, 32'hAAAA_0002, 0);
        step("stall3",      1,   0,   1,   0,    32'h0000_7004, 32'hAAAA_0003, 1);
        step("stall_eret",  1,   0,   1,   1,    32'h0000_301C, 32'hAAAA_0004, 0);
        step("stall_req",   1,   1,   1,   0,    32'h0000_3020, 32'hAAAA_0005, 0);
        step("release",     1,   0,   0,   0,    32'h0000_3024, 32'h0000_0000, 0);
        step("eret",        1,   0,   0,   1,    32'h0000_3008, 32'h1234_5678, 1);
        step("eret_req",    1,   1,   0,   1,    32'h0000_3008, 32'h1234_5678, 1);
        step("reload",      1,   0,   0,   0,    32'h0000_4000, 32'h0BAD_F00D, 1);
        step("stall4",      1,   0,   1,   0,    32'h0000_4004, 32'h5555_5555, 0);
        step("rst_stall",   0,   0,   1,   0,    32'h0000_4008, 32'h6666_6666, 1);
        step("resume",      1,   0,   0,   0,    32'h0000_400C, 32'h7777_7777, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
